// File: rtl/mod_n_updown_counter.sv
`default_nettype none
// ============================================================================
// Module      : mod_n_updown_counter
// Description : Synchronous modulo-N up/down counter with active-low parallel
//               load, 74161-style enp/ent enables, ripple carry and a
//               registered wrap pulse. Optional count-rate prescaler is
//               enabled by defining the macro CNT_PRESCALE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mod_n_updown_counter #(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 16,
    parameter int PRESCALE = 4
) (
    input  logic             clk,
    input  logic             mr,
    input  logic             load,
    input  logic             enp,
    input  logic             ent,
    input  logic             up,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             co,
    output logic             wrap
);

    localparam logic [WIDTH:0]   c_MOD = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH-1:0] c_MAX = WIDTH'(MODULUS - 1);

    generate
        if (MODULUS < 2 || MODULUS > (2 ** WIDTH)) begin : g_bad_modulus
            $error("mod_n_updown_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
        end
        if (PRESCALE < 1) begin : g_bad_prescale
            $error("mod_n_updown_counter: PRESCALE must be >= 1");
        end
    endgenerate

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             wrap_q, wrap_d;
    logic             w_tc;
    logic             w_tick;
    logic             w_en;

    assign w_en = enp & ent;
    assign w_tc = up ? (cnt_q == c_MAX) : (cnt_q == '0);

`ifdef CNT_PRESCALE_EN
    localparam int             c_PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [c_PW-1:0] c_PMAX = c_PW'(PRESCALE - 1);

    logic [c_PW-1:0] pcnt_q, pcnt_d;

    assign w_tick = (pcnt_q == c_PMAX);

    always_comb begin
        pcnt_d = pcnt_q;
        if (!load) begin
            pcnt_d = '0;
        end else if (w_en) begin
            pcnt_d = w_tick ? '0 : pcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge mr) begin
        if (!mr) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_d;
        end
    end
`else
    assign w_tick = 1'b1;
`endif

    // A count step at the terminal value is exactly a boundary crossing.
    always_comb begin
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        if (!load) begin
            cnt_d = ({1'b0, d} < c_MOD) ? d : c_MAX;
        end else if (w_en && w_tick) begin
            if (w_tc) begin
                wrap_d = 1'b1;
                cnt_d  = up ? '0 : c_MAX;
            end else begin
                cnt_d  = up ? cnt_q + 1'b1 : cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge mr) begin
        if (!mr) begin
            cnt_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
        end
    end

    // mr gates co so a down-counting stage held in reset never reports carry.
    assign co   = mr & ent & w_tc & w_tick;
    assign q    = cnt_q;
    assign wrap = wrap_q;

endmodule
`default_nettype wire

// File: tb/tb_mod_n_updown_counter.sv
`default_nettype none
// Self-checking bench for mod_n_updown_counter (WIDTH=4, MODULUS=10) against
// an arithmetic reference model; prescale scenarios run when CNT_PRESCALE_EN is set.
module tb_mod_n_updown_counter;

    localparam int W   = 4;
    localparam int MOD = 10;
    localparam int P   = 4;
`ifdef CNT_PRESCALE_EN
    localparam int STEP = P;
`else
    localparam int STEP = 1;
`endif

    logic         clk = 1'b0;
    logic         mr, load, enp, ent, up;
    logic [W-1:0] d;
    logic [W-1:0] q;
    logic         co, wrap;

    int tests = 0;
    int fails = 0;

    int m_q    = 0;
    int m_wrap = 0;
    int m_p    = 0;

    mod_n_updown_counter #(.WIDTH(W), .MODULUS(MOD), .PRESCALE(P)) dut (
        .clk  (clk),
        .mr   (mr),
        .load (load),
        .enp  (enp),
        .ent  (ent),
        .up   (up),
        .d    (d),
        .q    (q),
        .co   (co),
        .wrap (wrap)
    );

    always #5 clk = ~clk;

    function automatic bit m_tick();
`ifdef CNT_PRESCALE_EN
        return (m_p == P - 1);
`else
        return 1'b1;
`endif
    endfunction

    function automatic logic m_co();
        if (!mr) return 1'b0;
        return ent && m_tick() && ((up && m_q == MOD - 1) || (!up && m_q == 0));
    endfunction

    // Advance one rising edge and update the reference model from the inputs
    // that were stable before the edge.
    task automatic tick_clk();
        int nq = m_q;
        int nw = 0;
        int np = m_p;
        if (!mr) begin
            nq = 0; np = 0;
        end else if (!load) begin
            nq = (int'(d) < MOD) ? int'(d) : MOD - 1;
            np = 0;
        end else if (enp && ent) begin
            if (m_tick()) begin
                np = 0;
                if (up) begin
                    nq = (m_q + 1) % MOD;
                    nw = (nq == 0);
                end else begin
                    nq = (m_q + MOD - 1) % MOD;
                    nw = (m_q == 0);
                end
            end else begin
                np = m_p + 1;
            end
        end
        @(posedge clk);
        #1;
        m_q = nq; m_wrap = nw; m_p = np;
    endtask

    task automatic do_load(input int val);
        load = 1'b0; d = W'(val);
        tick_clk();
        load = 1'b1;
    endtask

    task automatic test_reset();
        mr = 1'b1; load = 1'b1; enp = 1'b0; ent = 1'b1; up = 1'b0; d = '0;
        #2 mr = 1'b0;
        #1;
        tests++; if (q !== 4'd0) begin fails++; $display("FAIL reset_q: got %0d expected 0", q); end
        tests++; if (wrap !== 1'b0) begin fails++; $display("FAIL reset_wrap: got %0b expected 0", wrap); end
        tests++; if (co !== 1'b0) begin fails++; $display("FAIL reset_co_down: got %0b expected 0", co); end
        @(negedge clk); mr = 1'b1;
        do_load(5);
        tests++; if (q !== W'(m_q)) begin fails++; $display("FAIL reset_load5: got %0d expected %0d", q, m_q); end
        #2 mr = 1'b0;
        #1;
        m_q = 0; m_wrap = 0; m_p = 0;
        tests++; if (q !== 4'd0) begin fails++; $display("FAIL midcount_reset_q: got %0d expected 0", q); end
        tests++; if (wrap !== 1'b0) begin fails++; $display("FAIL midcount_reset_wrap: got %0b expected 0", wrap); end
        @(negedge clk); mr = 1'b1; enp = 1'b1; ent = 1'b1; up = 1'b1;
        for (int i = 0; i < STEP; i++) tick_clk();
        tests++; if (q !== 4'd1) begin fails++; $display("FAIL release_first_count: got %0d expected 1", q); end
    endtask

    task automatic test_up_wrap();
        enp = 1'b1; ent = 1'b1; up = 1'b1;
        do_load(9);
        tests++; if (q !== 4'd9) begin fails++; $display("FAIL up_load9_q: got %0d expected 9", q); end
        tests++; if (co !== m_co()) begin fails++; $display("FAIL up_load9_co: got %0b expected %0b", co, m_co()); end
        for (int i = 0; i < STEP; i++) begin
            if (i == STEP - 1) begin
                tests++; if (co !== 1'b1) begin fails++; $display("FAIL up_tick_co: got %0b expected 1", co); end
            end
            tick_clk();
        end
        tests++; if (q !== 4'd0) begin fails++; $display("FAIL up_wrap_q: got %0d expected 0", q); end
        tests++; if (wrap !== 1'b1) begin fails++; $display("FAIL up_wrap_pulse: got %0b expected 1", wrap); end
        tests++; if (co !== 1'b0) begin fails++; $display("FAIL up_wrap_co: got %0b expected 0", co); end
        tick_clk();
        tests++; if (wrap !== 1'b0) begin fails++; $display("FAIL up_wrap_one_cycle: got %0b expected 0", wrap); end
    endtask

    task automatic test_down_wrap();
        enp = 1'b1; ent = 1'b1; up = 1'b0;
        do_load(0);
        tests++; if (co !== m_co()) begin fails++; $display("FAIL down_load0_co: got %0b expected %0b", co, m_co()); end
        for (int i = 0; i < STEP; i++) tick_clk();
        tests++; if (q !== 4'd9) begin fails++; $display("FAIL down_wrap_q: got %0d expected 9", q); end
        tests++; if (wrap !== 1'b1) begin fails++; $display("FAIL down_wrap_pulse: got %0b expected 1", wrap); end
        for (int i = 0; i < STEP; i++) tick_clk();
        tests++; if (q !== 4'd8) begin fails++; $display("FAIL down_step_q: got %0d expected 8", q); end
        tests++; if (wrap !== 1'b0) begin fails++; $display("FAIL down_step_wrap: got %0b expected 0", wrap); end
    endtask

    task automatic test_enables();
        up = 1'b1; enp = 1'b1; ent = 1'b0;
        do_load(9);
        #1;
        tests++; if (co !== 1'b0) begin fails++; $display("FAIL ent0_co: got %0b expected 0", co); end
        tick_clk();
        tests++; if (q !== 4'd9) begin fails++; $display("FAIL ent0_hold: got %0d expected 9", q); end
        ent = 1'b1; enp = 1'b0;
        #1;
        tests++; if (co !== m_co()) begin fails++; $display("FAIL enp0_co: got %0b expected %0b", co, m_co()); end
        tick_clk();
        tests++; if (q !== 4'd9) begin fails++; $display("FAIL enp0_hold: got %0d expected 9", q); end
    endtask

    task automatic test_load_corner();
        enp = 1'b0; ent = 1'b0; up = 1'b1;
        do_load(12);
        tests++; if (q !== 4'd9) begin fails++; $display("FAIL load_clamp: got %0d expected 9", q); end
        enp = 1'b1; ent = 1'b1;
        for (int i = 0; i < STEP - 1; i++) tick_clk();
        load = 1'b0; d = 4'd3;
        tick_clk();
        load = 1'b1;
        tests++; if (q !== 4'd3) begin fails++; $display("FAIL load_over_count_q: got %0d expected 3", q); end
        tests++; if (wrap !== 1'b0) begin fails++; $display("FAIL load_over_count_wrap: got %0b expected 0", wrap); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            load = ($urandom_range(0, 9) == 0) ? 1'b0 : 1'b1;
            enp  = ($urandom_range(0, 5) != 0);
            ent  = ($urandom_range(0, 5) != 0);
            up   = ($urandom_range(0, 3) != 0);
            d    = W'($urandom_range(0, 15));
            #1;
            tests++; if (co !== m_co()) begin fails++; $display("FAIL rand_co[%0d]: got %0b expected %0b", i, co, m_co()); end
            tick_clk();
            tests++; if (q !== W'(m_q)) begin fails++; $display("FAIL rand_q[%0d]: got %0d expected %0d", i, q, m_q); end
            tests++; if (wrap !== 1'(m_wrap)) begin fails++; $display("FAIL rand_wrap[%0d]: got %0b expected %0d", i, wrap, m_wrap); end
        end
    endtask

`ifdef CNT_PRESCALE_EN
    task automatic test_prescale();
        int wraps = 0;
        int co_cnt = 0;
        enp = 1'b1; ent = 1'b1; up = 1'b1;
        do_load(0);
        for (int i = 0; i < 4; i++) tick_clk();
        tests++; if (q !== 4'd1) begin fails++; $display("FAIL presc_q1: got %0d expected 1", q); end
        for (int i = 0; i < 4; i++) tick_clk();
        tests++; if (q !== 4'd2) begin fails++; $display("FAIL presc_q2: got %0d expected 2", q); end
        for (int i = 0; i < 40; i++) begin
            if (co === 1'b1) co_cnt++;
            tick_clk();
            if (wrap === 1'b1) wraps++;
        end
        tests++; if (wraps != 1) begin fails++; $display("FAIL presc_wraps_per_40: got %0d expected 1", wraps); end
        tests++; if (co_cnt != 1) begin fails++; $display("FAIL presc_co_pulses: got %0d expected 1", co_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_up_wrap();
        test_down_wrap();
        test_enables();
        test_load_corner();
        test_random();
`ifdef CNT_PRESCALE_EN
        test_prescale();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
